mac_spike_scheduler: RTL
========================

MAC_SPIKE_SCHEDULER -- requirements
Module: mac_spike_scheduler

Interface
REQ-001 Parameter ADDR_W, default 12: neuron/source address width.
REQ-002 Parameter N_SYN, default 5: synapse slots per neuron.
REQ-003 Parameter FIFO_DEPTH, default 8: spike FIFO entries, power of two.
REQ-004 Parameter ADD_LAT, default 2: cycles the MAC adder needs between successive mac_add_en pulses.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 CLK  in  1  sole clock; all state changes on rising edge.
REQ-007 RESETn  in  1  asynchronous active-low reset.
REQ-008 timestep_start  in  1  one-cycle pulse that opens a timestep.
REQ-009 spike_valid  in  1  incoming spike present.
REQ-010 spike_addr  in  ADDR_W  source address of the incoming spike.
REQ-011 spike_ready  out  1  FIFO can accept; equals not-full.
REQ-012 src_addr_array  in  N_SYN*ADDR_W  slot k at bits [ADDR_W*k+ADDR_W-1 : ADDR_W*k].
REQ-013 weight_array  in  N_SYN*32  IEEE-754 single weight; slot k at bits [32k+31:32k].
REQ-014 mac_clear  out  1  accumulator clear pulse.
REQ-015 mac_add_en  out  1  one-cycle add request to the MAC.
REQ-016 mac_weight  out  32  weight for the current add; valid while mac_add_en=1.
REQ-017 mac_source_address  out  ADDR_W  spike address being dispatched.
REQ-018 step_done  out  1  one-cycle pulse when the timestep's spikes are consumed.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 miss_count  out  16  unmatched-spike counter (see Configuration).

Function
REQ-021 Spike push on spike_valid & spike_ready, in any state; at full, spike_ready=0 and no push occurs.
REQ-022 FSM states: IDLE, CLEAR, DISPATCH, WAIT, DONE.
REQ-023 IDLE: timestep_start=1 -> CLEAR; timestep_start in any other state is ignored.
REQ-024 CLEAR (1 cycle): mac_clear=1; snapshot current FIFO occupancy into pending counter, including a push in the same cycle; -> DISPATCH.
REQ-025 DISPATCH, pending=0: -> DONE.
REQ-026 DISPATCH, pending>0: pop one entry and decrement pending; compare against all N_SYN slots; on match, lowest matching index wins.
REQ-027 On match: in the same cycle, assert mac_add_en=1, mac_weight=matched slot weight, mac_source_address=popped address; -> WAIT.
REQ-028 On no match: no mac_add_en; remain in DISPATCH; next entry popped next cycle.
REQ-029 WAIT holds ADD_LAT-1 cycles (0 cycles if ADD_LAT=1), then -> DISPATCH; consecutive add pulses are therefore spaced at least ADD_LAT cycles apart.
REQ-030 DONE (1 cycle): step_done=1; -> IDLE.
REQ-031 Spikes pushed after the CLEAR snapshot are not dispatched in the current timestep; they wait for the next one.
REQ-032 Simultaneous push and pop: both take effect; occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-033 mac_clear, mac_add_en and step_done are registered outputs, zero outside their defined cycles.

Reset
REQ-034 RESETn=0 immediately forces: IDLE; FIFO empty; pending=0; mac_clear=0; mac_add_en=0; mac_weight=0; mac_source_address=0; step_done=0; busy=0; miss_count=0; spike_ready=1 from the first edge after release.
REQ-035 Reset mid-timestep discards all queued spikes; no step_done is issued.

Configuration
REQ-036 Macro MAC_SCHED_MISS_CNT_EN defined: miss_count increments on each REQ-028 no-match pop and saturates at 16'hFFFF; it never clears except by reset.
REQ-037 MAC_SCHED_MISS_CNT_EN undefined: miss_count is tied to 0 and no counter is built.

Verification
REQ-038 Slots {7,6,0,4,3}; push 3, 5, 7; pulse timestep_start -> mac_clear once; adds 42AE3852 (addr 3), then 4290B333 (addr 7), spaced ADD_LAT cycles; 5 unmatched; step_done after the last pop; miss_count=1 with the macro defined.
REQ-039 Empty FIFO, pulse timestep_start -> mac_clear, then step_done 2 cycles later, with no mac_add_en.
REQ-040 Push 9 spikes with depth 8 -> spike_ready=0 after the 8th push; the 9th is held; spike_ready=1 on the first pop.
REQ-041 Push 2 spikes, start step, push a 3rd during WAIT -> only 2 dispatched; the 3rd is dispatched in the next step.
REQ-042 Duplicate slot address 4 in slots 1 and 3 -> the weight of slot 1 is used.
REQ-043 Assert RESETn=0 during WAIT -> outputs zero asynchronously; FIFO empty; no step_done; a new step after release completes normally.

Source files
------------

// File: rtl/mac_spike_scheduler.sv
// Spike FIFO plus FSM that dispatches each queued spike to a floating-point MAC.
// Optional miss counter is built only when MAC_SCHED_MISS_CNT_EN is defined.
module mac_spike_scheduler #(
    parameter int ADDR_W     = 12,
    parameter int N_SYN      = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int ADD_LAT    = 2
) (
    input  logic                     CLK,
    input  logic                     RESETn,
    input  logic                     timestep_start,
    input  logic                     spike_valid,
    input  logic [ADDR_W-1:0]        spike_addr,
    output logic                     spike_ready,
    input  logic [N_SYN*ADDR_W-1:0]  src_addr_array,
    input  logic [N_SYN*32-1:0]      weight_array,
    output logic                     mac_clear,
    output logic                     mac_add_en,
    output logic [31:0]              mac_weight,
    output logic [ADDR_W-1:0]        mac_source_address,
    output logic                     step_done,
    output logic                     busy,
    output logic [15:0]              miss_count
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((ADD_LAT > 1) ? ADD_LAT - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DISPATCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Spike FIFO
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_nxt;
    logic [ADDR_W-1:0] head;
    logic              push, pop;

    logic [CNT_W-1:0]  pending, pending_nxt;

    assign spike_ready = (fifo_cnt != FULL_CNT);
    assign push        = spike_valid && spike_ready;
    assign pop         = (state == S_DISPATCH) && (pending != '0);
    assign head        = fifo_mem[rd_ptr];

    always_comb begin
        unique case ({push, pop})
            2'b10:   fifo_cnt_nxt = fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt_nxt = fifo_cnt - CNT_W'(1);
            default: fifo_cnt_nxt = fifo_cnt;
        endcase
    end

    // NOTE: storage has no reset; emptiness is defined by the pointers and count alone.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= spike_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Slot match: scan high to low so the lowest matching index wins
    // ------------------------------------------------------------------
    logic        hit;
    logic [31:0] hit_weight;

    always_comb begin
        hit        = 1'b0;
        hit_weight = '0;
        for (int k = N_SYN - 1; k >= 0; k--) begin
            if (src_addr_array[ADDR_W*k +: ADDR_W] == head) begin
                hit        = 1'b1;
                hit_weight = weight_array[32*k +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              clear_nxt, add_nxt, done_nxt;
    logic [31:0]       weight_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        wait_nxt    = wait_cnt;
        clear_nxt   = 1'b0;
        add_nxt     = 1'b0;
        done_nxt    = 1'b0;
        weight_nxt  = mac_weight;
        addr_nxt    = mac_source_address;

        unique case (state)
            S_IDLE: begin
                if (timestep_start) begin
                    state_nxt = S_CLEAR;
                    clear_nxt = 1'b1;
                end
            end
            S_CLEAR: begin
                // A push landing in this very cycle belongs to this timestep.
                pending_nxt = fifo_cnt_nxt;
                state_nxt   = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (pending == '0) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    pending_nxt = pending - CNT_W'(1);
                    if (hit) begin
                        add_nxt    = 1'b1;
                        weight_nxt = hit_weight;
                        addr_nxt   = head;
                        if (ADD_LAT > 1) begin
                            state_nxt = S_WAIT;
                            wait_nxt  = WAIT_INIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = S_DISPATCH;
                end else begin
                    wait_nxt = wait_cnt - WAIT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state              <= S_IDLE;
            pending            <= '0;
            wait_cnt           <= '0;
            mac_clear          <= 1'b0;
            mac_add_en         <= 1'b0;
            step_done          <= 1'b0;
            mac_weight         <= '0;
            mac_source_address <= '0;
        end else begin
            state              <= state_nxt;
            pending            <= pending_nxt;
            wait_cnt           <= wait_nxt;
            mac_clear          <= clear_nxt;
            mac_add_en         <= add_nxt;
            step_done          <= done_nxt;
            mac_weight         <= weight_nxt;
            mac_source_address <= addr_nxt;
        end
    end

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Unmatched-spike counter (saturating, cleared only by reset)
    // ------------------------------------------------------------------
`ifdef MAC_SCHED_MISS_CNT_EN
    logic        miss_inc;
    logic [15:0] miss_q;

    assign miss_inc = pop && !hit;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            miss_q <= '0;
        end else if (miss_inc && (miss_q != 16'hFFFF)) begin
            miss_q <= miss_q + 16'd1;
        end
    end

    assign miss_count = miss_q;
`else
    assign miss_count = '0;
`endif

endmodule
